// File: rtl/multi_delay.sv
// Multi-channel programmable delay/period generator: NCH independent counters,
// each in periodic or one-shot mode, with a shared period-load port and overrun flagging.

module multi_delay_ch #(
    parameter int CBITS = 13,
    parameter int N_DEF = 7500
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             oneshot,
    input  logic             start,
    input  logic             ld,
    input  logic [CBITS-1:0] ld_val,
    input  logic             err_clr,
    output logic             sig,
    output logic             flg,
    output logic             err,
    output logic             run
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [CBITS-1:0] cnt, cnt_nxt;
    logic [CBITS-1:0] p;
    logic             err_set;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_set   = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!oneshot || start) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end
                end
                RUN: begin
                    // increment only below P, so the counter can never wrap
                    if (cnt < p) begin
                        cnt_nxt = cnt + 1'b1;
                    end else begin
                        cnt_nxt = '0;
                        if (cnt == p) begin
                            if (oneshot)
                                state_nxt = IDLE;
                        end else begin
                            err_set = 1'b1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            p     <= CBITS'(N_DEF);
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (ld)
                p <= ld_val;
            // a new overrun beats a simultaneous clear
            if (err_set)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;
        end
    end

    assign run = (state == RUN);
    assign sig = run && (cnt == p);
    assign flg = run && (cnt < p);

endmodule

module multi_delay #(
    parameter int NCH   = 4,
    parameter int CBITS = 13,
    parameter int N_DEF = 7500,
    parameter int CHW   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   en,
    input  logic [NCH-1:0]   oneshot,
    input  logic [NCH-1:0]   start,
    input  logic             ld,
    input  logic [CHW-1:0]   ld_ch,
    input  logic [CBITS-1:0] ld_val,
    input  logic [NCH-1:0]   err_clr,
    output logic [NCH-1:0]   sig,
    output logic [NCH-1:0]   flg,
    output logic [NCH-1:0]   err,
    output logic             busy
);

    logic [NCH-1:0] run;

    // ld_ch values at or above NCH match no channel and are dropped
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        multi_delay_ch #(
            .CBITS (CBITS),
            .N_DEF (N_DEF)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en[g]),
            .oneshot (oneshot[g]),
            .start   (start[g]),
            .ld      (ld && (ld_ch == CHW'(g))),
            .ld_val  (ld_val),
            .err_clr (err_clr[g]),
            .sig     (sig[g]),
            .flg     (flg[g]),
            .err     (err[g]),
            .run     (run[g])
        );
    end

    assign busy = |run;

endmodule

// File: tb/tb_multi_delay.sv
// Randomized and directed bench for multi_delay against a cycle-level behavioural model.

module tb_multi_delay;

    localparam int NCH   = 4;
    localparam int CBITS = 13;
    localparam int N_DEF = 7500;
    localparam int CHW   = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH-1:0]   en, oneshot, start, err_clr;
    logic             ld;
    logic [CHW-1:0]   ld_ch;
    logic [CBITS-1:0] ld_val;
    logic [NCH-1:0]   sig, flg, err;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model: per channel, running flag, elapsed count, period, sticky error
    bit m_run [NCH];
    int m_cnt [NCH];
    int m_p   [NCH];
    bit m_err [NCH];

    always #5 clk = ~clk;

    multi_delay #(.NCH(NCH), .CBITS(CBITS), .N_DEF(N_DEF), .CHW(CHW)) dut (
        .clk(clk), .rst(rst), .en(en), .oneshot(oneshot), .start(start),
        .ld(ld), .ld_ch(ld_ch), .ld_val(ld_val), .err_clr(err_clr),
        .sig(sig), .flg(flg), .err(err), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NCH; i++) begin
            m_run[i] = 0; m_cnt[i] = 0; m_p[i] = N_DEF; m_err[i] = 0;
        end
    endtask

    task automatic m_step();
        bit ov;
        for (int i = 0; i < NCH; i++) begin
            ov = en[i] && m_run[i] && (m_cnt[i] > m_p[i]);
            if (!en[i]) begin
                m_run[i] = 0; m_cnt[i] = 0;
            end else if (!m_run[i]) begin
                if (!oneshot[i] || start[i]) begin m_run[i] = 1; m_cnt[i] = 0; end
            end else if (m_cnt[i] < m_p[i]) begin
                m_cnt[i] = m_cnt[i] + 1;
            end else begin
                if (m_cnt[i] == m_p[i] && oneshot[i]) m_run[i] = 0;
                m_cnt[i] = 0;
            end
            if (ov) m_err[i] = 1;
            else if (err_clr[i]) m_err[i] = 0;
        end
        if (ld && int'(ld_ch) < NCH) m_p[ld_ch] = int'(ld_val);
    endtask

    task automatic check_outs();
        logic [NCH-1:0] es, ef, ee;
        logic eb;
        eb = 0;
        for (int i = 0; i < NCH; i++) begin
            es[i] = m_run[i] && (m_cnt[i] == m_p[i]);
            ef[i] = m_run[i] && (m_cnt[i] <  m_p[i]);
            ee[i] = m_err[i];
            eb    = eb | m_run[i];
        end
        chk("sig",  32'(sig),  32'(es));
        chk("flg",  32'(flg),  32'(ef));
        chk("err",  32'(err),  32'(ee));
        chk("busy", 32'(busy), 32'(eb));
    endtask

    // inputs change only on the falling edge; model and DUT both sample at the rising edge
    task automatic tick();
        @(posedge clk);
        if (!rst) m_step();
        @(negedge clk);
        check_outs();
    endtask

    task automatic load(input int ch, input int val);
        ld = 1'b1; ld_ch = CHW'(ch); ld_val = CBITS'(val);
        tick();
        ld = 1'b0;
    endtask

    initial begin
        int first, second, npulse, nf, ns, ns1, k;
        rst = 1'b1; en = '0; oneshot = '0; start = '0; err_clr = '0;
        ld = 1'b0; ld_ch = '0; ld_val = '0;
        m_reset();
        @(negedge clk);
        chk("rst_sig",  32'(sig),  0);
        chk("rst_flg",  32'(flg),  0);
        chk("rst_err",  32'(err),  0);
        chk("rst_busy", 32'(busy), 0);
        tick();
        rst = 1'b0;
        tick();

        // default period on channel 0
        en = 4'b0001; first = 0; second = 0; npulse = 0;
        for (int c = 1; c <= 15010; c++) begin
            tick();
            if (sig[0]) begin
                npulse++;
                if (first == 0) first = c;
                else if (second == 0) second = c;
            end
        end
        chk("p038_first",  first,  7501);
        chk("p038_second", second, 15002);
        chk("p038_npulse", npulse, 2);

        // one-shot, retrigger attempt mid-run
        en = '0; tick();
        load(1, 3);
        en = 4'b0010; oneshot = 4'b0010; start = 4'b0010;
        tick();
        nf = int'(flg[1]); ns = int'(sig[1]);
        for (int c = 0; c < 8; c++) begin
            start = (c == 1) ? 4'b0010 : 4'b0000;
            tick();
            nf += int'(flg[1]); ns += int'(sig[1]);
        end
        chk("p039_flg_cycles", nf, 3);
        chk("p039_sig_cycles", ns, 1);
        chk("p039_busy", 32'(busy), 0);

        // overrun via reload below current count
        en = '0; oneshot = '0; start = '0; tick();
        load(2, 10);
        en = 4'b0100;
        for (int c = 0; c < 9; c++) tick();
        load(2, 5);
        tick();
        chk("p040_err_set", 32'(err[2]), 1);
        k = 1;
        while (!sig[2] && k < 20) begin tick(); k++; end
        chk("p040_gap", k, 6);
        chk("p040_sticky", 32'(err[2]), 1);
        err_clr = 4'b0100; tick(); err_clr = '0;
        chk("p040_clr", 32'(err[2]), 0);

        // P=0 constant expiry; out-of-range load index ignored
        en = '0; tick();
        load(3, 0);
        en = 4'b1010;
        load(5, 1);
        ns = 0; nf = 0; ns1 = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            ns += int'(sig[3]); nf += int'(flg[3]); ns1 += int'(sig[1]);
        end
        chk("p041_sig3", ns, 12);
        chk("p041_flg3", nf, 0);
        chk("p041_ch1_period", ns1, 3);

        // asynchronous reset mid-count
        en = 4'b1111;
        for (int c = 0; c < 20; c++) tick();
        #2 rst = 1'b1;
        m_reset();
        #1;
        chk("p042_sig",  32'(sig),  0);
        chk("p042_flg",  32'(flg),  0);
        chk("p042_busy", 32'(busy), 0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 30; c++) tick();

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NCH; i++) begin
                en[i]      = ($urandom_range(0, 19) != 0);
                oneshot[i] = ($urandom_range(0, 2) == 0);
                start[i]   = ($urandom_range(0, 3) == 0);
                err_clr[i] = ($urandom_range(0, 7) == 0);
            end
            ld     = ($urandom_range(0, 3) == 0);
            ld_ch  = CHW'($urandom_range(0, 7));
            ld_val = ($urandom_range(0, 49) == 0) ? {CBITS{1'b1}} : CBITS'($urandom_range(0, 12));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
